ixc_sample_hist: RTL and testbench
==================================

// Module: ixc_sample_hist
// PURPOSE
//   Parametrised successor to the fixed 32-bit sample latch. Replaces the transparent latch with a
//   clocked sample register, and keeps a DEPTH-entry history FIFO of sampled values for readout.
//   The sample strobes arrive as ports, not hierarchical references. Optional change-only capture.
//   Sits between emulated design signals and the emulator upload/readback path.
// PARAMETERS
//   WIDTH        32  sampled vector width, >= 1
//   DEPTH        8   history entries; power of 2, >= 2
//   CHANGE_ONLY  0   1: capture only when v differs from sv (or first capture since reset)
// PORTS
//   clk           in   1                    sampling clock
//   rst           in   1                    asynchronous, active-high reset
//   sample_ov     in   1                    sample-override strobe
//   call_emu_pre  in   1                    pre-emulation-call sample strobe
//   v             in   WIDTH                vector to sample
//   sv            out  WIDTH                last captured value (registered)
//   sv_vld        out  1                    at least one capture since reset
//   rd_valid      out  1                    history FIFO not empty
//   rd_ready      in   1                    consumer accepts rd_data this cycle
//   rd_data       out  WIDTH                oldest history entry
//   level         out  $clog2(DEPTH+1)      entries held, 0..DEPTH
//   ovf           out  1                    sticky: an entry was overwritten
//   clr_ovf       in   1                    synchronous clear of ovf
// BEHAVIOUR
//   - Reset: sv=0, sv_vld=0, rd_valid=0, rd_data=0, level=0, ovf=0. Pointers go to 0. FIFO contents are don't-care.
//   - do_sample = sample_ov | call_emu_pre, evaluated at the posedge of clk.
//   - cap = do_sample & (CHANGE_ONLY==0 | ~sv_vld | (v != sv)).
//   - cap: sv <= v and sv_vld <= 1 at the same edge. sv is visible 1 cycle after the strobe.
//     When cap=0, sv holds its value.
//   - cap also pushes v into the FIFO. There is no bypass: rd_valid rises the cycle after a push into an empty FIFO.
//   - pop = rd_valid & rd_ready. rd_data = entry at the read pointer. rd_data is stable while rd_valid=1 & rd_ready=0.
//   - Cases:
//       push, not full              -> write at wptr, wptr++, level++
//       pop, no push                -> rptr++, level--
//       push & pop                  -> both pointers advance; level unchanged (covers full and non-empty)
//       push & full & no pop        -> overwrite oldest: write at wptr, wptr++, rptr++;
//                                      level stays DEPTH; ovf <= 1
//       pop while empty             -> impossible (rd_valid=0); rd_ready ignored
//   - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is a separate counter.
//   - ovf is sticky. clr_ovf clears it next cycle. Overflow in the same cycle as clr_ovf leaves ovf=1 (set wins).
//   - rst asserted mid-operation discards all history immediately, independent of the clock.
//     After rst deasserts, the first strobe always captures, including when CHANGE_ONLY=1.
//   - sv and history capture do not depend on rd_ready. Sampling never stalls.
// TESTING
//   1. Reset, then pulse call_emu_pre with v=32'hDEAD_BEEF
//        -> next cycle: sv=DEADBEEF, sv_vld=1, rd_valid=1, level=1, rd_data=DEADBEEF.
//   2. Back-to-back strobes, v=1..8, rd_ready=0, DEPTH=8
//        -> level=8, ovf=0. Then pop all 8 -> rd_data order 1..8, then rd_valid=0, level=0.
//   3. Full FIFO holding 1..8, strobe with v=9, rd_ready=0
//        -> level=8, ovf=1, rd_data=2. Pop order 2..9.
//   4. Full FIFO, strobe v=9 with rd_ready=1 in the same cycle
//        -> pops 1; level=8; ovf stays 0.
//   5. CHANGE_ONLY=1: strobes with v=5,5,5,7
//        -> two entries (5,7), sv=7. Assert rst mid-sequence, then strobe v=7 -> level=1, rd_data=7.
//   6. Overflow and clr_ovf in the same cycle -> ovf=1. clr_ovf alone next cycle -> ovf=0 the cycle after.

Source files
------------

// File: rtl/ixc_sample_hist.sv
// Clocked sample register with a DEPTH-entry history FIFO of captured values.
// The FIFO overwrites its oldest entry when full and flags that with a sticky ovf bit.
module ixc_sample_hist #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 8,
  parameter int CHANGE_ONLY = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_ov,
  input  logic                           call_emu_pre,
  input  logic [WIDTH-1:0]               v,
  output logic [WIDTH-1:0]               sv,
  output logic                           sv_vld,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [WIDTH-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           ovf,
  input  logic                           clr_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] sv_q, sv_d;
  logic             sv_vld_q, sv_vld_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic do_sample;
  logic cap;
  logic pop;
  logic full;
  logic overwrite;

  // Read side handshake: an entry transfers on any edge where rd_valid & rd_ready;
  // rd_data stays on the same entry while rd_valid is high and rd_ready is low.
  assign do_sample = sample_ov | call_emu_pre;
  assign cap       = do_sample & ((CHANGE_ONLY == 0) | ~sv_vld_q | (v != sv_q));
  assign rd_valid  = (level_q != '0);
  assign pop       = rd_valid & rd_ready;
  assign full      = (level_q == LVL_FULL);
  assign overwrite = cap & full & ~pop;

  always_comb begin
    sv_d     = sv_q;
    sv_vld_d = sv_vld_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    level_d  = level_q;
    if (cap) begin
      sv_d     = v;
      sv_vld_d = 1'b1;
      wptr_d   = wptr_q + PTR_ONE;
    end
    // A full push without a pop drops the oldest entry by advancing the read side too.
    if (pop || overwrite) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    if (cap && !pop && !full) begin
      level_d = level_q + LVL_ONE;
    end else if (pop && !cap) begin
      level_d = level_q - LVL_ONE;
    end
    ovf_d = (ovf_q & ~clr_ovf) | overwrite;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sv_q     <= '0;
      sv_vld_q <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sv_q     <= sv_d;
      sv_vld_q <= sv_vld_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset; reads are masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (cap) begin
      mem_q[wptr_q] <= v;
    end
  end

  assign sv      = sv_q;
  assign sv_vld  = sv_vld_q;
  assign rd_data = rd_valid ? mem_q[rptr_q] : '0;
  assign level   = level_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_ixc_sample_hist.sv
// Bench for ixc_sample_hist: a default instance and a CHANGE_ONLY instance share the stimulus
// and are each compared against a queue-based model of the history.
module tb_ixc_sample_hist;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_ov = 1'b0;
  logic        call_emu_pre = 1'b0;
  logic [31:0] v = '0;
  logic        rd_ready = 1'b0;
  logic        clr_ovf = 1'b0;

  logic [31:0] sv0, rd_data0, sv1, rd_data1;
  logic        sv_vld0, rd_valid0, ovf0, sv_vld1, rd_valid1, ovf1;
  logic [3:0]  level0, level1;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] m_sv [2];
  logic        m_vld [2];
  logic        m_ovf [2];

  ixc_sample_hist #(.WIDTH(32), .DEPTH(DEPTH), .CHANGE_ONLY(0)) dut0 (
    .clk(clk), .rst(rst), .sample_ov(sample_ov), .call_emu_pre(call_emu_pre), .v(v),
    .sv(sv0), .sv_vld(sv_vld0), .rd_valid(rd_valid0), .rd_ready(rd_ready),
    .rd_data(rd_data0), .level(level0), .ovf(ovf0), .clr_ovf(clr_ovf)
  );

  ixc_sample_hist #(.WIDTH(32), .DEPTH(DEPTH), .CHANGE_ONLY(1)) dut1 (
    .clk(clk), .rst(rst), .sample_ov(sample_ov), .call_emu_pre(call_emu_pre), .v(v),
    .sv(sv1), .sv_vld(sv_vld1), .rd_valid(rd_valid1), .rd_ready(rd_ready),
    .rd_data(rd_data1), .level(level1), .ovf(ovf1), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    for (int k = 0; k < 2; k++) begin
      m_sv[k]  = '0;
      m_vld[k] = 1'b0;
      m_ovf[k] = 1'b0;
    end
  endtask

  // One clock edge of the history: consumer takes the front, a capture appends,
  // and a capture into a full history discards the front and raises overflow.
  task automatic model_edge();
    logic [31:0] q[$];
    logic do_s, take, ovf_set;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) q = exp_q0; else q = exp_q1;
      do_s    = sample_ov | call_emu_pre;
      take    = do_s && ((k == 0) || !m_vld[k] || (v != m_sv[k]));
      ovf_set = 1'b0;
      if (rd_ready && q.size() > 0) q.delete(0);
      if (take) begin
        if (q.size() == DEPTH) begin
          q.delete(0);
          ovf_set = 1'b1;
        end
        q.push_back(v);
        m_sv[k]  = v;
        m_vld[k] = 1'b1;
      end
      m_ovf[k] = (m_ovf[k] & ~clr_ovf) | ovf_set;
      if (k == 0) exp_q0 = q; else exp_q1 = q;
    end
  endtask

  task automatic cycle(input logic so, input logic ce, input logic [31:0] vv,
                       input logic rr, input logic co);
    @(negedge clk);
    sample_ov    = so;
    call_emu_pre = ce;
    v            = vv;
    rd_ready     = rr;
    clr_ovf      = co;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic assert_rst();
    @(negedge clk);
    sample_ov = 1'b0; call_emu_pre = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_1_to_8();
    for (int i = 1; i <= DEPTH; i++) cycle(1'b0, 1'b1, 32'(i), 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (sv0 !== 32'h0) begin n_errors++; $display("FAIL reset_sv: got %h want 0", sv0); end
    n_checks++; if (sv_vld0 !== 1'b0) begin n_errors++; $display("FAIL reset_sv_vld: got %b want 0", sv_vld0); end
    n_checks++; if (rd_valid0 !== 1'b0) begin n_errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid0); end
    n_checks++; if (rd_data0 !== 32'h0) begin n_errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data0); end
    n_checks++; if (level0 !== 4'd0) begin n_errors++; $display("FAIL reset_level: got %0d want 0", level0); end
    n_checks++; if (ovf0 !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b want 0", ovf0); end
    model_reset();
    release_rst();
  endtask

  task automatic test_first_capture();
    cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    n_checks++; if (sv0 !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL first_sv: got %h want deadbeef", sv0); end
    n_checks++; if (sv_vld0 !== 1'b1) begin n_errors++; $display("FAIL first_sv_vld: got %b want 1", sv_vld0); end
    n_checks++; if (rd_valid0 !== 1'b1) begin n_errors++; $display("FAIL first_rd_valid: got %b want 1", rd_valid0); end
    n_checks++; if (level0 !== 4'd1) begin n_errors++; $display("FAIL first_level: got %0d want 1", level0); end
    n_checks++; if (rd_data0 !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL first_rd_data: got %h want deadbeef", rd_data0); end
    cycle(1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
    n_checks++; if (sv0 !== 32'h1234_5678) begin n_errors++; $display("FAIL ov_strobe_sv: got %h want 12345678", sv0); end
    n_checks++; if (rd_data0 !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL hold_rd_data: got %h want deadbeef", rd_data0); end
    cycle(1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    n_checks++; if (sv0 !== 32'h1234_5678) begin n_errors++; $display("FAIL idle_sv_hold: got %h want 12345678", sv0); end
    n_checks++; if (level0 !== 4'd2) begin n_errors++; $display("FAIL idle_level: got %0d want 2", level0); end
  endtask

  task automatic test_fill_drain();
    assert_rst();
    release_rst();
    fill_1_to_8();
    n_checks++; if (level0 !== 4'd8) begin n_errors++; $display("FAIL fill_level: got %0d want 8", level0); end
    n_checks++; if (ovf0 !== 1'b0) begin n_errors++; $display("FAIL fill_ovf: got %b want 0", ovf0); end
    for (int i = 1; i <= DEPTH; i++) begin
      n_checks++;
      if (rd_data0 !== 32'(i)) begin n_errors++; $display("FAIL drain_order: got %h want %h", rd_data0, 32'(i)); end
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    end
    n_checks++; if (rd_valid0 !== 1'b0) begin n_errors++; $display("FAIL drain_rd_valid: got %b want 0", rd_valid0); end
    n_checks++; if (level0 !== 4'd0) begin n_errors++; $display("FAIL drain_level: got %0d want 0", level0); end
  endtask

  task automatic test_overflow();
    assert_rst();
    release_rst();
    fill_1_to_8();
    cycle(1'b0, 1'b1, 32'd9, 1'b0, 1'b0);
    n_checks++; if (level0 !== 4'd8) begin n_errors++; $display("FAIL ovf_level: got %0d want 8", level0); end
    n_checks++; if (ovf0 !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b want 1", ovf0); end
    n_checks++; if (rd_data0 !== 32'd2) begin n_errors++; $display("FAIL ovf_rd_data: got %h want 2", rd_data0); end
    for (int i = 2; i <= 9; i++) begin
      n_checks++;
      if (rd_data0 !== 32'(i)) begin n_errors++; $display("FAIL ovf_order: got %h want %h", rd_data0, 32'(i)); end
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    end
    n_checks++; if (ovf0 !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b want 1", ovf0); end
  endtask

  task automatic test_back_to_back();
    assert_rst();
    release_rst();
    fill_1_to_8();
    cycle(1'b0, 1'b1, 32'd9, 1'b1, 1'b0);
    n_checks++; if (level0 !== 4'd8) begin n_errors++; $display("FAIL pushpop_level: got %0d want 8", level0); end
    n_checks++; if (ovf0 !== 1'b0) begin n_errors++; $display("FAIL pushpop_ovf: got %b want 0", ovf0); end
    n_checks++; if (rd_data0 !== 32'd2) begin n_errors++; $display("FAIL pushpop_rd_data: got %h want 2", rd_data0); end
    cycle(1'b0, 1'b1, 32'd10, 1'b1, 1'b0);
    n_checks++; if (rd_data0 !== 32'd3) begin n_errors++; $display("FAIL pushpop2_rd_data: got %h want 3", rd_data0); end
    n_checks++; if (level0 !== 4'd8) begin n_errors++; $display("FAIL pushpop2_level: got %0d want 8", level0); end
  endtask

  task automatic test_ovf_clear();
    assert_rst();
    release_rst();
    fill_1_to_8();
    cycle(1'b0, 1'b1, 32'd9, 1'b0, 1'b1);
    n_checks++; if (ovf0 !== 1'b1) begin n_errors++; $display("FAIL ovf_set_wins: got %b want 1", ovf0); end
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    n_checks++; if (ovf0 !== 1'b0) begin n_errors++; $display("FAIL ovf_cleared: got %b want 0", ovf0); end
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    n_checks++; if (ovf0 !== 1'b0) begin n_errors++; $display("FAIL ovf_stays_clear: got %b want 0", ovf0); end
  endtask

  task automatic test_change_only();
    assert_rst();
    release_rst();
    cycle(1'b0, 1'b1, 32'd5, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'd5, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'd5, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'd7, 1'b0, 1'b0);
    n_checks++; if (level1 !== 4'd2) begin n_errors++; $display("FAIL co_level: got %0d want 2", level1); end
    n_checks++; if (sv1 !== 32'd7) begin n_errors++; $display("FAIL co_sv: got %h want 7", sv1); end
    n_checks++; if (rd_data1 !== 32'd5) begin n_errors++; $display("FAIL co_rd_data: got %h want 5", rd_data1); end
    n_checks++; if (level0 !== 4'd4) begin n_errors++; $display("FAIL all_level: got %0d want 4", level0); end
    assert_rst();
    n_checks++; if (level1 !== 4'd0) begin n_errors++; $display("FAIL async_rst_level: got %0d want 0", level1); end
    n_checks++; if (rd_valid1 !== 1'b0) begin n_errors++; $display("FAIL async_rst_rd_valid: got %b want 0", rd_valid1); end
    n_checks++; if (sv_vld1 !== 1'b0) begin n_errors++; $display("FAIL async_rst_sv_vld: got %b want 0", sv_vld1); end
    release_rst();
    cycle(1'b0, 1'b1, 32'd7, 1'b0, 1'b0);
    n_checks++; if (level1 !== 4'd1) begin n_errors++; $display("FAIL co_post_rst_level: got %0d want 1", level1); end
    n_checks++; if (rd_data1 !== 32'd7) begin n_errors++; $display("FAIL co_post_rst_rd_data: got %h want 7", rd_data1); end
    assert_rst();
    release_rst();
    cycle(1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
    n_checks++; if (level1 !== 4'd1) begin n_errors++; $display("FAIL co_first_zero_level: got %0d want 1", level1); end
    n_checks++; if (sv_vld1 !== 1'b1) begin n_errors++; $display("FAIL co_first_zero_vld: got %b want 1", sv_vld1); end
    cycle(1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
    n_checks++; if (level1 !== 4'd1) begin n_errors++; $display("FAIL co_repeat_zero_level: got %0d want 1", level1); end
  endtask

  task automatic test_random();
    logic [31:0] e_rd0, e_rd1;
    assert_rst();
    release_rst();
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)),
            1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) == 0));
      e_rd0 = (exp_q0.size() > 0) ? exp_q0[0] : 32'h0;
      e_rd1 = (exp_q1.size() > 0) ? exp_q1[0] : 32'h0;
      n_checks++; if (sv0 !== m_sv[0]) begin n_errors++; $display("FAIL rnd_sv0: got %h want %h", sv0, m_sv[0]); end
      n_checks++; if (sv_vld0 !== m_vld[0]) begin n_errors++; $display("FAIL rnd_sv_vld0: got %b want %b", sv_vld0, m_vld[0]); end
      n_checks++; if (rd_valid0 !== (exp_q0.size() > 0)) begin n_errors++; $display("FAIL rnd_rd_valid0: got %b want %0d", rd_valid0, exp_q0.size()); end
      n_checks++; if (rd_data0 !== e_rd0) begin n_errors++; $display("FAIL rnd_rd_data0: got %h want %h", rd_data0, e_rd0); end
      n_checks++; if (level0 !== 4'(exp_q0.size())) begin n_errors++; $display("FAIL rnd_level0: got %0d want %0d", level0, exp_q0.size()); end
      n_checks++; if (ovf0 !== m_ovf[0]) begin n_errors++; $display("FAIL rnd_ovf0: got %b want %b", ovf0, m_ovf[0]); end
      n_checks++; if (sv1 !== m_sv[1]) begin n_errors++; $display("FAIL rnd_sv1: got %h want %h", sv1, m_sv[1]); end
      n_checks++; if (sv_vld1 !== m_vld[1]) begin n_errors++; $display("FAIL rnd_sv_vld1: got %b want %b", sv_vld1, m_vld[1]); end
      n_checks++; if (rd_valid1 !== (exp_q1.size() > 0)) begin n_errors++; $display("FAIL rnd_rd_valid1: got %b want %0d", rd_valid1, exp_q1.size()); end
      n_checks++; if (rd_data1 !== e_rd1) begin n_errors++; $display("FAIL rnd_rd_data1: got %h want %h", rd_data1, e_rd1); end
      n_checks++; if (level1 !== 4'(exp_q1.size())) begin n_errors++; $display("FAIL rnd_level1: got %0d want %0d", level1, exp_q1.size()); end
      n_checks++; if (ovf1 !== m_ovf[1]) begin n_errors++; $display("FAIL rnd_ovf1: got %b want %b", ovf1, m_ovf[1]); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_capture();
    test_fill_drain();
    test_overflow();
    test_back_to_back();
    test_ovf_clear();
    test_change_only();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
